// File: rtl/dmem_hs.sv
// dmem_hs: single-port word memory with byte write enables, a fixed-latency
// read pipeline and a credit-controlled show-ahead response FIFO.
//   CLK, RST          : clock, asynchronous active-high reset
//   REQ_VALID/READY   : request handshake (READY registered, credit based)
//   REQ_WE            : byte write enables, all-zero selects a read
//   REQ_ADDR/WDATA    : word address and write data
//   RSP_VALID/READY   : response handshake, head of the response FIFO
//   RSP_RDATA         : read data of the FIFO head
module dmem_hs #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned RESP_DEPTH   = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic [DATA_WIDTH/8-1:0] REQ_WE,
    input  logic [ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [DATA_WIDTH-1:0]   REQ_WDATA,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [DATA_WIDTH-1:0]   RSP_RDATA
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    logic rd_acc;
    logic wr_acc;
    logic push;
    logic pop;

    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]      credits_q, credits_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [RESP_DEPTH];
    logic                  pipe_vld_q  [READ_LATENCY];
    logic                  pipe_vld_d  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_data_d [READ_LATENCY];

    // Handshake qualifiers
    always_comb begin
        rd_acc = REQ_VALID && ready_q && (REQ_WE == '0);
        wr_acc = REQ_VALID && ready_q && (REQ_WE != '0);
        pop    = rsp_valid_q && RSP_READY;
        push   = pipe_vld_q[READ_LATENCY-1];
    end

    // Storage array: byte-masked write on the accept edge, never reset
    always_ff @(posedge CLK) begin
        for (int b = 0; b < int'(BYTES); b++) begin
            if (wr_acc && REQ_WE[b]) begin
                mem_q[REQ_ADDR][b*8 +: 8] <= REQ_WDATA[b*8 +: 8];
            end
        end
    end

    // Stage 0 is the memory read register; later stages are plain valid-tagged delays.
    // No stall is needed: credits guarantee a FIFO slot for every read in flight.
    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_data_d = pipe_data_q;
        pipe_vld_d[0] = rd_acc;
        if (rd_acc) begin
            pipe_data_d[0] = mem_q[REQ_ADDR];
        end
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // Response FIFO, pointers wrap naturally since depth is a power of two
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = pipe_data_q[READ_LATENCY-1];
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        rsp_valid_d = (count_d != '0);
    end

    // Credits cover reads in the pipeline plus FIFO occupancy
    always_comb begin
        case ({rd_acc, pop})
            2'b10:   credits_d = credits_q + CNT_W'(1);
            2'b01:   credits_d = credits_q - CNT_W'(1);
            default: credits_d = credits_q;
        endcase
        ready_d = (credits_d < CNT_W'(RESP_DEPTH));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            credits_q   <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_data_q[i] <= '0;
            end
        end else begin
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            credits_q   <= credits_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_q      <= fifo_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
        end
    end

    assign REQ_READY = ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_dmem_hs.sv
// Randomized scoreboard bench for dmem_hs plus directed corner scenarios and
// two small instances built with read latencies 1 and 4.
module tb_dmem_hs;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned RL    = 2;
    localparam int unsigned DEPTH = 4;

    logic          CLK;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [3:0]    REQ_WE;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_WDATA;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [DW-1:0] RSP_RDATA;

    logic          lt_valid     [2];
    logic          lt_req_ready [2];
    logic [3:0]    lt_we        [2];
    logic [3:0]    lt_addr      [2];
    logic [DW-1:0] lt_wdata     [2];
    logic          lt_rsp_valid [2];
    logic          lt_rsp_ready [2];
    logic [DW-1:0] lt_rdata     [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] exp_q [$];

    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = '0;

    dmem_hs #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .RESP_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA)
    );

    for (genvar g = 0; g < 2; g++) begin : g_lat
        localparam int unsigned L = (g == 0) ? 1 : 4;
        dmem_hs #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(4), .READ_LATENCY(L), .RESP_DEPTH(4)
        ) u_lat (
            .CLK(CLK), .RST(RST),
            .REQ_VALID(lt_valid[g]), .REQ_READY(lt_req_ready[g]), .REQ_WE(lt_we[g]),
            .REQ_ADDR(lt_addr[g]), .REQ_WDATA(lt_wdata[g]),
            .RSP_VALID(lt_rsp_valid[g]), .RSP_READY(lt_rsp_ready[g]), .RSP_RDATA(lt_rdata[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks hold stability
    always @(negedge CLK or posedge RST) begin
        if (RST) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("rsp_hold_valid", 64'(RSP_VALID), 64'(1));
                chk("rsp_hold_data", 64'(RSP_RDATA), 64'(held_d));
            end
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(RSP_RDATA), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("rsp_data", 64'(RSP_RDATA), 64'(exp_q.pop_front()));
                end
                held_v = 1'b0;
            end else if (RSP_VALID) begin
                held_v = 1'b1;
                held_d = RSP_RDATA;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    function automatic logic [AW-1:0] pick_addr();
        int a;
        a = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) a = 1023 - a;
        return AW'(a);
    endfunction

    // One request cycle; entered and left at posedge+1
    task automatic cycle(input bit v, input logic [3:0] we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit rr, output bit acc);
        logic [DW-1:0] w;
        chk("req_ready", 64'(REQ_READY), 64'(exp_q.size() < int'(DEPTH)));
        REQ_VALID = v;
        REQ_WE    = we;
        REQ_ADDR  = a;
        REQ_WDATA = d;
        RSP_READY = rr;
        @(negedge CLK);
        acc = v && REQ_READY;
        if (acc) begin
            if (we != 4'h0) begin
                w = ref_mem[a];
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) w[b*8 +: 8] = d[b*8 +: 8];
                end
                ref_mem[a] = w;
            end else begin
                exp_q.push_back(ref_mem[a]);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n;
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || RSP_VALID) && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("drain_done", 64'(n < 100), 64'(1));
    endtask

    task automatic wait_rsp(input string name, input logic [DW-1:0] exp);
        int n;
        n = 0;
        while (!RSP_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk({name, "_valid"}, 64'(RSP_VALID), 64'(1));
        chk(name, 64'(RSP_RDATA), 64'(exp));
    endtask

    task automatic lat_run(input int g, input int lat);
        int n;
        lt_rsp_ready[g] = 1'b1;
        lt_valid[g] = 1'b1;
        lt_we[g]    = 4'hF;
        lt_addr[g]  = 4'd5;
        lt_wdata[g] = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk("lat_wr_ready", 64'(lt_req_ready[g]), 64'(1));
        @(posedge CLK);
        #1;
        lt_we[g] = 4'h0;
        @(negedge CLK);
        chk("lat_rd_ready", 64'(lt_req_ready[g]), 64'(1));
        @(posedge CLK);
        #1;
        lt_valid[g] = 1'b0;
        n = 0;
        while (!lt_rsp_valid[g] && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("lat_edges", 64'(n), 64'(lat));
        chk("lat_data", 64'(lt_rdata[g]), 64'h0000_0000_DEAD_BEEF);
        @(posedge CLK);
        #1;
        chk("lat_popped", 64'(lt_rsp_valid[g]), 64'(0));
    endtask

    initial begin
        bit            acc;
        int            cnt;
        int            cyc;
        int            idx;
        int            n;
        bit            is_wr;
        logic [3:0]    we_r;
        logic [AW-1:0] a_r;

        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WE    = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        RSP_READY = 1'b0;
        for (int g = 0; g < 2; g++) begin
            lt_valid[g]     = 1'b0;
            lt_we[g]        = '0;
            lt_addr[g]      = '0;
            lt_wdata[g]     = '0;
            lt_rsp_ready[g] = 1'b0;
        end

        // Reset state
        #12;
        chk("rst_req_ready", 64'(REQ_READY), 64'(0));
        chk("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
        chk("rst_rsp_rdata", 64'(RSP_RDATA), 64'(0));
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("ready_before_first_edge", 64'(REQ_READY), 64'(0));
        @(posedge CLK);
        #1;

        // Define every address the random phase touches
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 4'hF, AW'(i), $urandom, 1'b1, acc);
            cycle(1'b1, 4'hF, AW'(1023 - i), $urandom, 1'b1, acc);
        end
        drain();

        // Write then read next cycle, latency from accept edge
        cycle(1'b1, 4'hF, AW'(5), 32'hDEAD_BEEF, 1'b1, acc);
        chk("wr5_accept", 64'(acc), 64'(1));
        cycle(1'b1, 4'h0, AW'(5), '0, 1'b1, acc);
        chk("rd5_accept", 64'(acc), 64'(1));
        REQ_VALID = 1'b0;
        n = 0;
        while (!RSP_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("rd_latency", 64'(n), 64'(RL));
        chk("rd5_data", 64'(RSP_RDATA), 64'h0000_0000_DEAD_BEEF);
        drain();

        // Partial byte write merge
        cycle(1'b1, 4'hF, AW'(7), 32'h1122_3344, 1'b1, acc);
        cycle(1'b1, 4'h1, AW'(7), 32'h0000_00AA, 1'b1, acc);
        cycle(1'b1, 4'h0, AW'(7), '0, 1'b1, acc);
        REQ_VALID = 1'b0;
        wait_rsp("byte_merge", 32'h1122_33AA);
        drain();

        // Backpressure: exactly DEPTH reads accepted, head held
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'h0, AW'(i), '0, 1'b0, acc);
            if (acc) cnt++;
        end
        chk("fill_accepts", 64'(cnt), 64'(DEPTH));
        chk("fill_ready_low", 64'(REQ_READY), 64'(0));

        // Release into back-to-back reads 0..15 from a full FIFO
        cyc = 0;
        idx = 0;
        while (idx < 16 && cyc < 40) begin
            cycle(1'b1, 4'h0, AW'(idx), '0, 1'b1, acc);
            cyc++;
            if (acc) idx++;
        end
        chk("b2b_accepts", 64'(idx), 64'(16));
        chk("b2b_cycles", 64'(cyc), 64'(17));
        drain();

        // Reset with reads in flight
        cycle(1'b1, 4'hF, AW'(9), 32'hCAFE_F00D, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'h0, AW'(9), '0, 1'b0, acc);
        end
        REQ_VALID = 1'b0;
        RST = 1'b1;
        #1;
        chk("mid_rst_req_ready", 64'(REQ_READY), 64'(0));
        chk("mid_rst_rsp_valid", 64'(RSP_VALID), 64'(0));
        chk("mid_rst_rsp_rdata", 64'(RSP_RDATA), 64'(0));
        exp_q.delete();
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'h0, '0, '0, 1'b1, acc);
        end
        chk("post_rst_no_rsp", 64'(RSP_VALID), 64'(0));
        cycle(1'b1, 4'h0, AW'(9), '0, 1'b1, acc);
        REQ_VALID = 1'b0;
        wait_rsp("post_rst_data", 32'hCAFE_F00D);
        drain();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            is_wr = ($urandom_range(0, 9) < 4);
            we_r  = is_wr ? 4'($urandom_range(1, 15)) : 4'h0;
            a_r   = pick_addr();
            cycle($urandom_range(0, 9) < 7, we_r, a_r, $urandom, $urandom_range(0, 9) < 7, acc);
        end
        drain();

        lat_run(0, 1);
        lat_run(1, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_hs.md
DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8, range 8..128.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 10: word address width; depth = 2**ADDR_WIDTH words.
REQ-003 The block SHALL take parameter READ_LATENCY, default 2: cycles from read accept to response, range 1..4.
REQ-004 The block SHALL take parameter RESP_DEPTH, default 4: response FIFO entries, a power of 2, range 2..16.
REQ-005 The block SHALL have one clock; reset SHALL be asynchronous and active-high, with ports named CLK and RST.
REQ-006 The block SHALL have port CLK, input, 1 bit: clock, all state on the rising edge.
REQ-007 The block SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-008 The block SHALL have port REQ_VALID, input, 1 bit: a request is present.
REQ-009 The block SHALL have port REQ_READY, output, 1 bit: the block can accept a request.
REQ-010 The block SHALL have port REQ_WE, input, DATA_WIDTH/8 bits: byte write enables; all-zero means read.
REQ-011 The block SHALL have port REQ_ADDR, input, ADDR_WIDTH bits: word address.
REQ-012 The block SHALL have port REQ_WDATA, input, DATA_WIDTH bits: write data.
REQ-013 The block SHALL have port RSP_VALID, output, 1 bit: read data is present.
REQ-014 The block SHALL have port RSP_READY, input, 1 bit: the consumer takes the response.
REQ-015 The block SHALL have port RSP_RDATA, output, DATA_WIDTH bits: read data, valid only while RSP_VALID=1.

Function
REQ-016 A request SHALL be accepted on a rising edge where REQ_VALID=1 and REQ_READY=1; at most one request SHALL be accepted per cycle.
REQ-017 An accepted write (REQ_WE!=0) SHALL update only the bytes i with REQ_WE[i]=1, on the accept edge, and SHALL produce no response.
REQ-018 An accepted read (REQ_WE=0) SHALL produce exactly one response carrying the word at REQ_ADDR.
REQ-019 Requests SHALL take effect in acceptance order: a read SHALL observe every write accepted before it, including a write accepted in the immediately preceding cycle.
REQ-020 Responses SHALL be returned in read acceptance order.
REQ-021 With the response FIFO empty and RSP_READY=1, a read accepted at edge k SHALL raise RSP_VALID after edge k+READ_LATENCY; the data path SHALL consist of a memory read register plus READ_LATENCY-1 valid-tagged pipeline stages.
REQ-022 Pipeline outputs SHALL enter a RESP_DEPTH-entry show-ahead FIFO whose head drives RSP_VALID/RSP_RDATA; an entry SHALL be popped on an edge where RSP_VALID=1 and RSP_READY=1.
REQ-023 RSP_VALID and RSP_RDATA SHALL remain stable while RSP_VALID=1 and RSP_READY=0.
REQ-024 A credit counter SHALL track the reads in the pipeline plus the FIFO occupancy, with range 0..RESP_DEPTH.
- +1 on a read accept; -1 on a pop; unchanged when both occur on the same edge.
REQ-025 REQ_READY SHALL equal (credits < RESP_DEPTH) and SHALL NOT depend on REQ_VALID or REQ_WE; writes SHALL also be blocked at full credits.
REQ-026 The FIFO SHALL therefore never overflow; pointers SHALL wrap modulo RESP_DEPTH.
REQ-027 A read and a pop on the same edge with the FIFO full SHALL be legal and SHALL lose no data.
REQ-028 Memory contents SHALL be undefined until written, and REQ_ADDR SHALL be used in full with no wrap or aliasing.

Reset
REQ-029 While RST=1, REQ_READY, RSP_VALID, the credit counter, the FIFO pointers and all pipeline valid bits SHALL be 0, and RSP_RDATA SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight and queued reads, which SHALL never be returned.
REQ-031 Memory contents SHALL NOT be altered by reset.
REQ-032 REQ_READY SHALL rise on the first rising edge after RST deasserts.

Verification
REQ-033 The bench SHALL cover: write 0xDEADBEEF to address 5 with WE=1111, then read 5 on the next cycle -> RSP_VALID after READ_LATENCY edges with data 0xDEADBEEF.
REQ-034 The bench SHALL cover: a full write of 0x11223344 to address 7, then a write of 0x000000AA with WE=0001, then read 7 -> 0x112233AA.
REQ-035 The bench SHALL cover: RSP_READY held 0 while reads are issued every cycle -> exactly RESP_DEPTH reads accepted, then REQ_READY=0, and data held stable; releasing RSP_READY returns the responses in order.
REQ-036 The bench SHALL cover: back-to-back reads of addresses 0..15 with RSP_READY=1 and the FIFO full -> throughput of one per cycle once the pipeline fills, and no drops on simultaneous accept/pop.
REQ-037 The bench SHALL cover: RST pulsed with 3 reads in flight -> RSP_VALID=0 and no stale response afterwards; reading a previously written address returns the pre-reset data.
REQ-038 The bench SHALL cover: READ_LATENCY=1 and READ_LATENCY=4 builds running the first scenario -> response after 1 and 4 edges respectively.
